// File: rtl/vector_int_unit.sv
// Four-lane integer vector unit: elementwise ops in one EXEC cycle, reductions over four RED cycles.
// Optional feature macro: VEC_SWIZZLE_EN enables opcode 12 (VSWIZZLE); otherwise opcode 12 is illegal.
module vector_int_unit #(
    parameter int W     = 36,
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op,
    input  logic [3:0]           mask,
    input  logic [LANES*W-1:0]   vs,
    input  logic [LANES*W-1:0]   vt,
    input  logic [W-1:0]         rt,
    input  logic [W-1:0]         prev_rd,
    input  logic [7:0]           swz,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   vd,
    output logic [W-1:0]         rd,
    output logic                 illegal
);

    localparam logic [3:0] OP_VADD     = 4'd0;
    localparam logic [3:0] OP_VSUB     = 4'd1;
    localparam logic [3:0] OP_VMULT    = 4'd2;
    localparam logic [3:0] OP_VDOT     = 4'd3;
    localparam logic [3:0] OP_VDOTA    = 4'd4;
    localparam logic [3:0] OP_VREDUCE  = 4'd5;
    localparam logic [3:0] OP_VSPLAT   = 4'd6;
    localparam logic [3:0] OP_VSADD    = 4'd7;
    localparam logic [3:0] OP_VSSUB    = 4'd8;
    localparam logic [3:0] OP_VSMULT   = 4'd9;
    localparam logic [3:0] OP_VSMA     = 4'd10;
    localparam logic [3:0] OP_VINDX    = 4'd11;
    localparam logic [3:0] OP_VSWIZZLE = 4'd12;

    typedef enum logic [1:0] {IDLE, EXEC, RED, DONE} state_t;

    state_t               state, state_nx;
    logic [1:0]           cnt;
    logic [W-1:0]         acc;
    logic [3:0]           op_q;
    logic [3:0]           mask_q;
    logic [LANES*W-1:0]   vs_q, vt_q;
    logic [W-1:0]         rt_q;
    logic [7:0]           swz_q;

    logic [LANES*W-1:0]   ew_vd;
    logic [W-1:0]         ew_rd;
    logic                 op_bad;
    logic [W-1:0]         a, b, lane;
    logic [W-1:0]         rl_vs, rl_vt, red_term;

    function automatic logic [W-1:0] lane_of(input logic [LANES*W-1:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    lane_of = v[0*W +: W];
            2'd1:    lane_of = v[1*W +: W];
            2'd2:    lane_of = v[2*W +: W];
            default: lane_of = v[3*W +: W];
        endcase
    endfunction

    function automatic logic is_red(input logic [3:0] o);
        is_red = (o == OP_VDOT) || (o == OP_VDOTA) || (o == OP_VREDUCE);
    endfunction

`ifdef VEC_SWIZZLE_EN
    assign op_bad = (op_q > OP_VSWIZZLE);
`else
    logic unused_swz;
    assign unused_swz = ^swz_q[7:2];
    assign op_bad     = (op_q >= OP_VSWIZZLE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = is_red(op) ? RED : EXEC;
            EXEC: state_nx = DONE;
            RED:  if (cnt == 2'd3) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Reset holds the FSM in IDLE, but the unit must not advertise readiness until reset is released.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    always_comb begin
        ew_vd = '0;
        ew_rd = '0;
        a     = '0;
        b     = '0;
        lane  = '0;
        for (int i = 0; i < LANES; i++) begin
            a    = vs_q[i*W +: W];
            b    = vt_q[i*W +: W];
            lane = '0;
            case (op_q)
                OP_VADD:     lane = a + b;
                OP_VSUB:     lane = a - b;
                OP_VMULT:    lane = a * b;
                OP_VSPLAT:   lane = rt_q;
                OP_VSADD:    lane = a + rt_q;
                OP_VSSUB:    lane = a - rt_q;
                OP_VSMULT:   lane = a * rt_q;
                OP_VSMA:     lane = a * rt_q + b;
`ifdef VEC_SWIZZLE_EN
                OP_VSWIZZLE: lane = lane_of(vs_q, swz_q[2*i +: 2]);
`endif
                default:     lane = '0;
            endcase
            if (mask_q[i]) ew_vd[i*W +: W] = lane;
        end
        if (op_q == OP_VINDX) begin
            ew_vd = '0;
            ew_rd = lane_of(vt_q, swz_q[1:0]);
        end
    end

    // One lane per RED cycle; disabled lanes contribute nothing to the running sum.
    always_comb begin
        rl_vs    = lane_of(vs_q, cnt);
        rl_vt    = lane_of(vt_q, cnt);
        red_term = '0;
        if (mask_q[cnt]) red_term = (op_q == OP_VREDUCE) ? rl_vt : rl_vs * rl_vt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            op_q    <= '0;
            mask_q  <= '0;
            vs_q    <= '0;
            vt_q    <= '0;
            rt_q    <= '0;
            swz_q   <= '0;
            vd      <= '0;
            rd      <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q   <= op;
                    mask_q <= mask;
                    vs_q   <= vs;
                    vt_q   <= vt;
                    rt_q   <= rt;
                    swz_q  <= swz;
                    cnt    <= '0;
                    acc    <= (op == OP_VDOTA) ? prev_rd : '0;
                end
                EXEC: begin
                    vd      <= op_bad ? '0 : ew_vd;
                    rd      <= op_bad ? '0 : ew_rd;
                    illegal <= op_bad;
                end
                RED: begin
                    cnt <= cnt + 2'd1;
                    acc <= acc + red_term;
                    if (cnt == 2'd3) begin
                        vd      <= '0;
                        rd      <= acc + red_term;
                        illegal <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_int_unit.sv
// Directed bench for vector_int_unit: latency, arithmetic, masking, handshake hold and reset abort.
module tb_vector_int_unit;

    localparam int W = 36;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     op;
    logic [3:0]     mask;
    logic [4*W-1:0] vs, vt;
    logic [W-1:0]   rt, prev_rd;
    logic [7:0]     swz;
    logic           out_valid;
    logic           out_ready;
    logic [4*W-1:0] vd;
    logic [W-1:0]   rd;
    logic           illegal;

    int total = 0;
    int bad   = 0;
    int lat;
    logic seen;

    vector_int_unit #(.W(W), .LANES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .mask(mask),
        .vs(vs), .vt(vt), .rt(rt), .prev_rd(prev_rd), .swz(swz), .out_valid(out_valid),
        .out_ready(out_ready), .vd(vd), .rd(rd), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [4*W-1:0] pack4(input logic [W-1:0] l0, l1, l2, l3);
        pack4 = {l3, l2, l1, l0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [4*W-1:0] observed, input logic [4*W-1:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issue one request and wait (bounded) for out_valid; lat counts cycles from acceptance.
    task automatic applyStimulus(input logic [3:0] o, input logic [3:0] m, input logic [4*W-1:0] s,
                                 input logic [4*W-1:0] t, input logic [W-1:0] r, input logic [W-1:0] p,
                                 input logic [7:0] z, output int latency);
        op = o; mask = m; vs = s; vt = t; rt = r; prev_rd = p; swz = z;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        latency = 1;
        while (!out_valid && latency < 20) begin
            step();
            latency++;
        end
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; mask = '0;
        vs = '0; vt = '0; rt = '0; prev_rd = '0; swz = '0;
        step(); step();
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_vd", vd, 0);
        checkOutput("rst_rd", rd, 0);
        checkOutput("rst_illegal", illegal, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);
        step();

        applyStimulus(4'd0, 4'b1111, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), 0, 0, 0, lat);
        checkOutput("vadd_lat", lat, 2);
        checkOutput("vadd_vd", vd, pack4(11, 22, 33, 44));
        checkOutput("vadd_rd", rd, 0);
        checkOutput("vadd_illegal", illegal, 0);
        releaseResult();

        applyStimulus(4'd4, 4'b0101, pack4(2, 3, 4, 5), pack4(7, 7, 7, 7), 0, 100, 0, lat);
        checkOutput("vdota_lat", lat, 5);
        checkOutput("vdota_rd", rd, 142);
        checkOutput("vdota_vd", vd, 0);
        releaseResult();

        applyStimulus(4'd1, 4'b0001, pack4(0, 5, 5, 5), pack4(1, 1, 1, 1), 0, 0, 0, lat);
        checkOutput("vsub_wrap_vd", vd, pack4(36'hFFFFFFFFF, 0, 0, 0));
        releaseResult();

        applyStimulus(4'd12, 4'hF, pack4(36'hA0000000A, 36'hB0000000B, 36'hC0000000C, 36'hD0000000D),
                      0, 0, 0, 8'b00011011, lat);
        checkOutput("vswz_lat", lat, 2);
`ifdef VEC_SWIZZLE_EN
        checkOutput("vswz_vd", vd, pack4(36'hD0000000D, 36'hC0000000C, 36'hB0000000B, 36'hA0000000A));
        checkOutput("vswz_illegal", illegal, 0);
`else
        checkOutput("vswz_vd", vd, 0);
        checkOutput("vswz_illegal", illegal, 1);
`endif
        releaseResult();

        applyStimulus(4'd2, 4'b1011, pack4(3, 36'h800000000, 7, 4), pack4(5, 2, 6, 9), 0, 0, 0, lat);
        checkOutput("vmult_vd", vd, pack4(15, 0, 0, 36));
        releaseResult();

        applyStimulus(4'd10, 4'b1111, pack4(1, 2, 3, 4), pack4(10, 10, 10, 10), 3, 0, 0, lat);
        checkOutput("vsma_vd", vd, pack4(13, 16, 19, 22));
        releaseResult();

        applyStimulus(4'd7, 4'b1111, pack4(36'hFFFFFFFFF, 1, 2, 3), 0, 1, 0, 0, lat);
        checkOutput("vsadd_vd", vd, pack4(0, 2, 3, 4));
        releaseResult();

        applyStimulus(4'd11, 4'b0000, pack4(9, 9, 9, 9), pack4(100, 200, 300, 400), 0, 0, 8'b11111110, lat);
        checkOutput("vindx_rd", rd, 300);
        checkOutput("vindx_vd", vd, 0);
        releaseResult();

        applyStimulus(4'd3, 4'b0000, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 0, 77, 0, lat);
        checkOutput("vdot_zero_mask_lat", lat, 5);
        checkOutput("vdot_zero_mask_rd", rd, 0);
        releaseResult();

        applyStimulus(4'd5, 4'b1110, pack4(50, 50, 50, 50), pack4(1, 2, 3, 4), 0, 0, 0, lat);
        checkOutput("vreduce_rd", rd, 9);
        releaseResult();

        applyStimulus(4'd14, 4'b1111, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 1, 1, 0, lat);
        checkOutput("illegal_lat", lat, 2);
        checkOutput("illegal_flag", illegal, 1);
        checkOutput("illegal_vd", vd, 0);
        checkOutput("illegal_rd", rd, 0);
        releaseResult();

        // Result must hold while the consumer stalls, and requests during DONE are ignored.
        applyStimulus(4'd8, 4'b1111, pack4(10, 20, 30, 40), 0, 5, 0, 0, lat);
        op = 4'd6; rt = 9; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("hold_vd", vd, pack4(5, 15, 25, 35));
            checkOutput("hold_rd", rd, 0);
            checkOutput("hold_in_ready", in_ready, 0);
            checkOutput("hold_out_valid", out_valid, 1);
        end
        releaseResult();
        in_valid = 1'b0;
        checkOutput("handshake_in_ready", in_ready, 1);
        checkOutput("handshake_out_valid", out_valid, 0);
        step();

        op = 4'd5; mask = 4'b1111; vt = pack4(1, 1, 1, 1); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checkOutput("abort_in_ready", in_ready, 0);
        checkOutput("abort_out_valid", out_valid, 0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("abort_release_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        checkOutput("abort_no_result", seen, 0);

        applyStimulus(4'd6, 4'b0110, pack4(1, 2, 3, 4), 0, 5, 0, 0, lat);
        checkOutput("vsplat_lat", lat, 2);
        checkOutput("vsplat_vd", vd, pack4(0, 5, 5, 0));
        releaseResult();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_int_unit.md
VECTOR_INT_UNIT -- requirements
Module: vector_int_unit

Interface
REQ-001 SHALL have parameter W, default 36, giving the lane and scalar width in bits.
REQ-002 SHALL have parameter LANES, default 4; the only supported value is 4.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  unit accepts a request.
REQ-007 op  input  4  opcode: 0 VADD, 1 VSUB, 2 VMULT, 3 VDOT, 4 VDOTA, 5 VREDUCE, 6 VSPLAT, 7 VSADD, 8 VSSUB, 9 VSMULT, 10 VSMA, 11 VINDX, 12 VSWIZZLE, 13-15 illegal.
REQ-008 mask  input  4  lane enable; bit i enables lane i.
REQ-009 vs  input  4*W  source vector; lane i occupies bits [i*W +: W].
REQ-010 vt  input  4*W  second source vector, same packing.
REQ-011 rt  input  W  scalar operand.
REQ-012 prev_rd  input  W  accumulator input for VDOTA.
REQ-013 swz  input  8  four 2-bit lane indices; index k is swz[2k+1:2k]; VINDX uses swz[1:0].
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 vd  output  4*W  vector result.
REQ-017 rd  output  W  scalar result.
REQ-018 illegal  output  1  current result came from an illegal opcode.

Function
REQ-019 The FSM SHALL have states IDLE, EXEC, RED and DONE.
REQ-020 in_ready SHALL equal (state==IDLE); a request is accepted when in_valid && in_ready, and all inputs are registered at acceptance.
REQ-021 After acceptance, a non-reduction op SHALL go IDLE->EXEC->DONE, so out_valid rises 2 cycles after acceptance.
REQ-022 After acceptance, VDOT, VDOTA and VREDUCE SHALL go IDLE->RED, process lane 0..3 one per cycle with a 2-bit counter, then enter DONE, so out_valid rises 5 cycles after acceptance whatever the mask.
REQ-023 In DONE, out_valid=1 and vd, rd and illegal SHALL stay stable until out_ready=1; the handshake cycle returns the FSM to IDLE.
REQ-024 Throughput SHALL be at most one op per 3 cycles for elementwise ops and one per 6 cycles for reductions; in_valid during a non-IDLE state SHALL be ignored.
REQ-025 All arithmetic SHALL wrap modulo 2^W; multiplies SHALL keep the low W bits of the product.
REQ-026 For elementwise ops, disabled lanes SHALL output 0; enabled lane i SHALL output:
  - VADD: vs+vt; VSUB: vs-vt; VMULT: vs*vt
  - VSPLAT: rt; VSADD: vs+rt; VSSUB: vs-rt; VSMULT: vs*rt
  - VSMA: vs*rt+vt
  - VSWIZZLE: vs[swz index i]
REQ-027 Reductions SHALL add only enabled lanes:
  - VDOT: rd = sum of vs*vt
  - VDOTA: rd = prev_rd + sum of vs*vt
  - VREDUCE: rd = sum of vt
  - An all-zero mask gives rd=0, or prev_rd for VDOTA.
REQ-028 VINDX SHALL give rd = vt lane swz[1:0] and SHALL ignore mask.
REQ-029 Ops that produce a scalar SHALL drive vd=0; ops that produce a vector SHALL drive rd=0.
REQ-030 An illegal opcode SHALL take the elementwise path with vd=0, rd=0 and illegal=1; illegal SHALL be 0 for every legal op.

Reset
REQ-031 rst=1 SHALL, asynchronously, force state IDLE, lane counter 0, accumulator 0, out_valid=0, vd=0, rd=0 and illegal=0.
REQ-032 During rst=1, in_ready SHALL be 0; it SHALL be 1 in the first cycle after rst deasserts.
REQ-033 An op in flight when rst asserts SHALL be discarded with no result emitted.

Configuration
REQ-034 Macro VEC_SWIZZLE_EN: when defined, opcode 12 SHALL perform VSWIZZLE; when undefined, opcode 12 SHALL be illegal (REQ-030) and no swizzle mux SHALL be synthesized.

Verification
REQ-035 VADD with mask=4'b1111, vs lanes {1,2,3,4}, vt lanes {10,20,30,40} -> vd lanes {11,22,33,44}, rd=0, out_valid 2 cycles after acceptance.
REQ-036 VDOTA with mask=4'b0101, vs lanes {2,3,4,5}, vt lanes {7,7,7,7}, prev_rd=100 -> rd=142, out_valid 5 cycles after acceptance.
REQ-037 VSUB with vs lane0=0, vt lane0=1, mask=4'b0001 -> vd lane0=36'hFFFFFFFFF, other lanes 0.
REQ-038 VSWIZZLE with swz=8'b00011011, vs lanes {A,B,C,D}, mask=4'hF -> vd lanes {D,C,B,A}; without VEC_SWIZZLE_EN -> illegal=1, vd=0.
REQ-039 Hold out_ready=0 for 3 cycles in DONE -> vd and rd stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 on the next cycle.
REQ-040 Assert rst 2 cycles into a VREDUCE -> out_valid never rises for that op; a VSPLAT with rt=5 issued after reset -> enabled lanes output 5.
